// File: rtl/vis_pkg.sv
// Shared widths, FSM state encoding and small arithmetic helpers for the vision pipeline.
package vis_pkg;

    localparam int POS_W   = 11;
    localparam int SUM_W   = 32;
    localparam int CNT_W   = 20;
    localparam int COORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_X   = 2'd1,
        DIV_Y   = 2'd2,
        PUBLISH = 2'd3
    } state_t;

    // Saturating increment: stops at lim instead of wrapping on malformed timing.
    function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v,
                                                 input logic [POS_W-1:0] lim);
        logic [POS_W-1:0] r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + {{(POS_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle. The start cycle already performs the
// first iteration, so a quotient is ready 32 cycles after start (done pulses then).
module seq_divider
    import vis_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    input  logic [CNT_W-1:0] divisor,
    output logic             done,
    output logic [SUM_W-1:0] quotient
);

    logic             busy_r;
    logic             done_r;
    logic [4:0]       iter_r;
    logic [CNT_W-1:0] rem_r;
    logic [SUM_W-1:0] quo_r;
    logic [CNT_W-1:0] dvs_r;
    logic [CNT_W:0]   step_s;

    // One restoring step: returns {quotient_bit, new_remainder}.
    function automatic logic [CNT_W:0] div_step(input logic [CNT_W-1:0] rem,
                                                 input logic             msb,
                                                 input logic [CNT_W-1:0] dvs);
        logic [CNT_W:0] trial;
        logic [CNT_W:0] res;
        trial = {rem, msb};
        if (trial >= {1'b0, dvs}) begin
            res = trial - {1'b0, dvs};
            res = {1'b1, res[CNT_W-1:0]};
        end else begin
            res = {1'b0, trial[CNT_W-1:0]};
        end
        return res;
    endfunction

    // Select operands for this cycle's step: live inputs on start, working regs while busy.
    always_comb begin
        step_s = {(CNT_W+1){1'b0}};
        if (busy_r) begin
            step_s = div_step(rem_r, quo_r[SUM_W-1], dvs_r);
        end else begin
            step_s = div_step({CNT_W{1'b0}}, dividend[SUM_W-1], divisor);
        end
    end

    // Iteration state: dividend bits shift out of quo_r as quotient bits shift in.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            iter_r <= 5'd0;
            rem_r  <= {CNT_W{1'b0}};
            quo_r  <= {SUM_W{1'b0}};
            dvs_r  <= {CNT_W{1'b0}};
        end else begin
            done_r <= 1'b0;
            if (busy_r) begin
                rem_r  <= step_s[CNT_W-1:0];
                quo_r  <= {quo_r[SUM_W-2:0], step_s[CNT_W]};
                iter_r <= iter_r + 5'd1;
                if (iter_r == 5'd31) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end
            end else if (start) begin
                rem_r  <= step_s[CNT_W-1:0];
                quo_r  <= {dividend[SUM_W-2:0], step_s[CNT_W]};
                dvs_r  <= divisor;
                iter_r <= 5'd1;
                busy_r <= 1'b1;
            end
        end
    end

    assign done     = done_r;
    assign quotient = quo_r;

endmodule

// File: rtl/centroid_ctrl.sv
// Per-frame centroid engine: tracks pixel position, accumulates mask coordinates over a
// frame, divides at frame end and publishes a tear-free centroid for the next frame.
module centroid_ctrl
    import vis_pkg::*;
#(
    parameter int IMG_H  = 720,
    parameter int IMG_W  = 1280,
    parameter int THRESH = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               de,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [23:0]        pixel_in,
    output logic [COORD_W-1:0] x_center,
    output logic [COORD_W-1:0] y_center,
    output logic               centroid_valid,
    output logic               no_object,
    output logic               frame_drop,
    output logic               busy
);

    localparam logic [POS_W-1:0] X_MAX   = POS_W'(IMG_W - 1);
    localparam logic [POS_W-1:0] Y_MAX   = POS_W'(IMG_H - 1);
    localparam logic [7:0]       THR     = 8'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic               vsync_r;
    logic               de_r;
    logic [POS_W-1:0]   x_pos_r;
    logic [POS_W-1:0]   y_pos_r;
    logic [SUM_W-1:0]   sum_x_r;
    logic [SUM_W-1:0]   sum_y_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [SUM_W-1:0]   snap_y_r;
    logic [CNT_W-1:0]   snap_cnt_r;
    logic [SUM_W-1:0]   qx_r;
    state_t             state_r;
    logic [COORD_W-1:0] x_center_r;
    logic [COORD_W-1:0] y_center_r;
    logic               valid_r;
    logic               no_obj_r;
    logic               drop_r;
    logic               busy_r;

    logic               mask_s;
    logic               fe_s;
    logic               de_fall_s;
    logic               acc_s;
    logic               div_start_s;
    logic [SUM_W-1:0]   div_dividend_s;
    logic [CNT_W-1:0]   div_divisor_s;
    logic               div_done_s;
    logic [SUM_W-1:0]   div_quot_s;
    logic               unused_s;

    assign mask_s    = (pixel_in[23:16] >= THR);
    assign fe_s      = vsync & ~vsync_r;
    assign de_fall_s = de_r & ~de;
    assign acc_s     = de & mask_s & ~vsync;
    // Line sync and green/blue are not needed for position or mask.
    assign unused_s  = ^{hsync, pixel_in[15:0]};

    // Edge-detect history for vsync and de.
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_r <= 1'b0;
            de_r    <= 1'b0;
        end else begin
            vsync_r <= vsync;
            de_r    <= de;
        end
    end

    // Pixel position counters; vsync has priority and counters saturate on bad timing.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_pos_r <= {POS_W{1'b0}};
            y_pos_r <= {POS_W{1'b0}};
        end else if (vsync) begin
            x_pos_r <= {POS_W{1'b0}};
            y_pos_r <= {POS_W{1'b0}};
        end else if (de) begin
            x_pos_r <= sat_inc(x_pos_r, X_MAX);
        end else if (de_fall_s) begin
            x_pos_r <= {POS_W{1'b0}};
            y_pos_r <= sat_inc(y_pos_r, Y_MAX);
        end
    end

    // Mask coordinate accumulators, cleared at every frame end whether or not it is accepted.
    always_ff @(posedge clk) begin
        if (rst || fe_s) begin
            sum_x_r <= {SUM_W{1'b0}};
            sum_y_r <= {SUM_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else if (acc_s) begin
            sum_x_r <= sum_x_r + SUM_W'(x_pos_r);
            sum_y_r <= sum_y_r + SUM_W'(y_pos_r);
            if (cnt_r != CNT_MAX) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Divider start: X launches on the snapshot cycle itself, Y as soon as X completes.
    always_comb begin
        div_start_s    = 1'b0;
        div_dividend_s = sum_x_r;
        div_divisor_s  = cnt_r;
        if ((state_r == IDLE) && fe_s && (cnt_r != {CNT_W{1'b0}})) begin
            div_start_s = 1'b1;
        end else if ((state_r == DIV_X) && div_done_s) begin
            div_start_s    = 1'b1;
            div_dividend_s = snap_y_r;
            div_divisor_s  = snap_cnt_r;
        end else begin
            div_start_s = 1'b0;
        end
    end

    seq_divider u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start_s),
        .dividend (div_dividend_s),
        .divisor  (div_divisor_s),
        .done     (div_done_s),
        .quotient (div_quot_s)
    );

    // Frame-end FSM with snapshot and registered outputs; centroid changes only in PUBLISH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            snap_y_r   <= {SUM_W{1'b0}};
            snap_cnt_r <= {CNT_W{1'b0}};
            qx_r       <= {SUM_W{1'b0}};
            x_center_r <= {COORD_W{1'b0}};
            y_center_r <= {COORD_W{1'b0}};
            valid_r    <= 1'b0;
            no_obj_r   <= 1'b0;
            drop_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            drop_r  <= fe_s && (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    if (fe_s) begin
                        snap_y_r   <= sum_y_r;
                        snap_cnt_r <= cnt_r;
                        if (cnt_r != {CNT_W{1'b0}}) begin
                            state_r <= DIV_X;
                            busy_r  <= 1'b1;
                        end else begin
                            no_obj_r <= 1'b1;
                        end
                    end
                end
                DIV_X: begin
                    if (div_done_s) begin
                        qx_r    <= div_quot_s;
                        state_r <= DIV_Y;
                    end
                end
                DIV_Y: begin
                    if (div_done_s) begin
                        state_r <= PUBLISH;
                        busy_r  <= 1'b0;
                    end
                end
                PUBLISH: begin
                    x_center_r <= COORD_W'(qx_r);
                    y_center_r <= COORD_W'(div_quot_s);
                    valid_r    <= 1'b1;
                    no_obj_r   <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign x_center       = x_center_r;
    assign y_center       = y_center_r;
    assign centroid_valid = valid_r;
    assign no_object      = no_obj_r;
    assign frame_drop     = drop_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_centroid_ctrl.sv
// Bench for centroid_ctrl: frame vectors from a table, expected centroids queued at frame
// end and popped when centroid_valid fires, plus hand sequences for drop and reset.
module tb_centroid_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [23:0] pixel_in;
    logic [31:0] x_center;
    logic [31:0] y_center;
    logic        centroid_valid;
    logic        no_object;
    logic        frame_drop;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;
    int held_x  = 0;
    int held_y  = 0;

    typedef struct {
        int x;
        int y;
    } res_t;
    res_t sb_q[$];

    typedef struct {
        string name;
        int    x0, y0, w, h, lines, line_w;
        bit    exp_valid;
        int    exp_x, exp_y;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    centroid_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .de             (de),
        .hsync          (hsync),
        .vsync          (vsync),
        .pixel_in       (pixel_in),
        .x_center       (x_center),
        .y_center       (y_center),
        .centroid_valid (centroid_valid),
        .no_object      (no_object),
        .frame_drop     (frame_drop),
        .busy           (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    endtask

    task automatic pop_check(input string nm);
        res_t r;
        chk({nm, "_sb_nonempty"}, 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            r = sb_q.pop_front();
            chk({nm, "_x"}, x_center, r.x);
            chk({nm, "_y"}, y_center, r.y);
            chk({nm, "_no_object"}, 32'(no_object), 32'd0);
        end
    endtask

    // Active lines: mask pixels use red=128 (on threshold), others red=127 (just below).
    task automatic drive_lines(input int x0, input int y0, input int w, input int h,
                               input int lines, input int line_w);
        for (int l = 0; l < lines; l++) begin
            for (int i = 0; i < line_w; i++) begin
                @(negedge clk);
                de = 1'b1; hsync = 1'b0;
                pixel_in = (i >= x0 && i < x0 + w && l >= y0 && l < y0 + h) ? 24'h80FFFF : 24'h7F0000;
            end
            for (int b = 0; b < 3; b++) begin
                @(negedge clk);
                de = 1'b0; hsync = 1'b1; pixel_in = 24'h000000;
            end
        end
        @(negedge clk);
        hsync = 1'b0;
        chk("hold_x_midframe", x_center, held_x);
        chk("hold_y_midframe", y_center, held_y);
    endtask

    task automatic frame_end(input string name, input bit exp_valid, input int ex, input int ey);
        int seen = 0;
        int lat = 0;
        int drops = 0;
        if (exp_valid) sb_q.push_back('{ex, ey});
        @(negedge clk);
        vsync = 1'b1; de = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 3) vsync = 1'b0;
            if (k == 10) chk({name, "_busy"}, 32'(busy), 32'(exp_valid));
            if (frame_drop) drops++;
            if (centroid_valid) begin
                seen++;
                if (lat == 0) lat = k;
                pop_check(name);
            end
        end
        chk({name, "_pulses"}, seen, exp_valid ? 32'd1 : 32'd0);
        chk({name, "_no_drop"}, drops, 32'd0);
        if (exp_valid) begin
            chk({name, "_latency"}, lat, 32'd66);
            held_x = ex; held_y = ey;
        end else begin
            chk({name, "_no_object"}, 32'(no_object), 32'd1);
            chk({name, "_held_x"}, x_center, held_x);
            chk({name, "_held_y"}, y_center, held_y);
        end
        chk({name, "_sb_drained"}, sb_q.size(), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        int seen, lat, drops, drop_c;

        vecs[0] = '{"single",    100, 50, 1,   1,  51, 128,  1'b1, 100,  50};
        vecs[1] = '{"black",       0,  0, 0,   0,   4,  32,  1'b0,   0,   0};
        vecs[2] = '{"quad_floor", 10, 10, 2,   2,  12,  16,  1'b1,  10,  10};
        vecs[3] = '{"rect",        5,  3, 3,   2,   6,  12,  1'b1,   6,   3};
        vecs[4] = '{"block",       0,  0, 128, 64, 64, 128,  1'b1,  63,  31};
        vecs[5] = '{"x_sat",    1299,  0, 1,   1,   1, 1300, 1'b1, 1279,  0};

        rst = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0; pixel_in = 24'h000000;
        repeat (3) @(negedge clk);
        chk("rst_x_center", x_center, 32'd0);
        chk("rst_y_center", y_center, 32'd0);
        chk("rst_valid", 32'(centroid_valid), 32'd0);
        chk("rst_no_object", 32'(no_object), 32'd0);
        chk("rst_frame_drop", 32'(frame_drop), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            drive_lines(vecs[v].x0, vecs[v].y0, vecs[v].w, vecs[v].h, vecs[v].lines, vecs[v].line_w);
            frame_end(vecs[v].name, vecs[v].exp_valid, vecs[v].exp_x, vecs[v].exp_y);
        end

        // Second frame end 20 cycles into the division: dropped, first result still published.
        drive_lines(20, 5, 1, 1, 6, 32);
        sb_q.push_back('{20, 5});
        seen = 0; lat = -1; drops = 0; drop_c = -1;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk);
            vsync = (c < 2) || (c >= 20 && c < 23);
            de = (c >= 5 && c < 10);
            pixel_in = de ? 24'hC80000 : 24'h000000;
            @(posedge clk); #1;
            if (c == 21) chk("drop_busy", 32'(busy), 32'd1);
            if (frame_drop) begin drops++; drop_c = c; end
            if (centroid_valid) begin seen++; lat = c; pop_check("drop_first"); end
        end
        chk("drop_pulses", drops, 32'd1);
        chk("drop_cycle", drop_c, 32'd20);
        chk("drop_valid_pulses", seen, 32'd1);
        chk("drop_valid_cycle", lat, 32'd65);
        held_x = 20; held_y = 5;
        frame_end("after_drop_cleared", 1'b0, 0, 0);

        // Reset while the Y division is running.
        drive_lines(7, 3, 1, 1, 4, 16);
        @(negedge clk);
        vsync = 1'b1;
        for (int c = 0; c < 45; c++) begin
            @(posedge clk); #1;
            if (c == 2) vsync = 1'b0;
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_x_center", x_center, 32'd0);
        chk("mid_rst_y_center", y_center, 32'd0);
        chk("mid_rst_valid", 32'(centroid_valid), 32'd0);
        chk("mid_rst_no_object", 32'(no_object), 32'd0);
        chk("mid_rst_frame_drop", 32'(frame_drop), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk); #1;
            if (centroid_valid) seen++;
        end
        chk("mid_rst_no_pulse", seen, 32'd0);
        held_x = 0; held_y = 0;
        drive_lines(9, 2, 1, 1, 3, 16);
        frame_end("post_rst", 1'b1, 9, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
